// File: rtl/superfx_pkg.sv
// Shared types and constants for the SuperFX instruction fetch path.
package superfx_pkg;

    localparam int ROM_ADDR_W = 24;
    localparam int OPCODE_W   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ADV  = 2'd2
    } fetch_state_t;

    function automatic logic [ROM_ADDR_W-1:0] rom_byte_addr(input logic [7:0] bank,
                                                            input logic [15:0] pc_val);
        return {bank, pc_val};
    endfunction

endpackage

// File: rtl/superfx_opcode_fifo.sv
// Small shift-style opcode FIFO; entry 0 is always the head so op_data comes straight from a flop.
module superfx_opcode_fifo
    import superfx_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush_i,
    input  logic                push_i,
    input  logic [OPCODE_W-1:0] push_data_i,
    input  logic                pop_i,
    output logic                valid_o,
    output logic [OPCODE_W-1:0] head_o,
    output logic                full_o
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [OPCODE_W-1:0] mem_q [DEPTH];
    logic [OPCODE_W-1:0] mem_d [DEPTH];
    logic [CW-1:0]       count_q;
    logic [CW-1:0]       count_d;
    logic                pop_s;
    logic                push_s;

    // Next-state: flush wins; otherwise shift out on pop, then append at the post-pop tail.
    always_comb begin
        pop_s   = pop_i && (count_q != {CW{1'b0}});
        push_s  = push_i && ((count_q != CW'(DEPTH)) || pop_s);
        mem_d   = mem_q;
        count_d = count_q;
        if (flush_i) begin
            for (int i = 0; i < DEPTH; i++) mem_d[i] = {OPCODE_W{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            if (pop_s) begin
                for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i + 1];
                mem_d[DEPTH-1] = {OPCODE_W{1'b0}};
                count_d        = count_d - CW'(1);
            end else begin
                count_d = count_d;
            end
            if (push_s) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (CW'(i) == count_d) mem_d[i] = push_data_i;
                end
                count_d = count_d + CW'(1);
            end else begin
                count_d = count_d;
            end
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= {OPCODE_W{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
        end
    end

    assign valid_o = (count_q != {CW{1'b0}});
    assign head_o  = mem_q[0];
    assign full_o  = (count_q == CW'(DEPTH));

endmodule

// File: rtl/superfx_fetch_unit.sv
// SuperFX opcode fetch unit: IDLE/REQ/ADV sequencer feeding an opcode FIFO.
// Define SUPERFX_FETCH_PREFETCH_EN for a 2-deep queue (prefetch); default is 1-deep.
module superfx_fetch_unit
    import superfx_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic                  flush,
    input  logic [15:0]           pc,
    input  logic [7:0]            pbr,
    output logic                  pcen,
    output logic                  cchld,
    output logic                  rom_req,
    output logic [ROM_ADDR_W-1:0] rom_addr,
    input  logic                  rom_ack,
    input  logic [OPCODE_W-1:0]   rom_data,
    output logic                  op_valid,
    output logic [OPCODE_W-1:0]   op_data,
    input  logic                  op_ready
);

`ifdef SUPERFX_FETCH_PREFETCH_EN
    localparam int QDEPTH = 2;
`else
    localparam int QDEPTH = 1;
`endif

    fetch_state_t          state_q;
    fetch_state_t          state_d;
    logic                  discard_q;
    logic                  discard_d;
    logic [ROM_ADDR_W-1:0] addr_q;
    logic [ROM_ADDR_W-1:0] addr_d;
    logic                  push_s;
    logic                  pop_s;
    logic                  full_s;

    // Sequencer: the address is captured on entry to REQ so a mid-access PC reload cannot move it.
    always_comb begin
        state_d   = state_q;
        discard_d = discard_q;
        addr_d    = addr_q;
        push_s    = 1'b0;
        case (state_q)
            IDLE: begin
                if (go && !flush && !full_s) begin
                    state_d = REQ;
                    addr_d  = rom_byte_addr(pbr, pc);
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (rom_ack) begin
                    discard_d = 1'b0;
                    if (discard_q || flush) begin
                        state_d = IDLE;
                    end else begin
                        state_d = ADV;
                        push_s  = 1'b1;
                    end
                end else if (flush) begin
                    discard_d = 1'b1;
                end else begin
                    state_d = REQ;
                end
            end
            ADV: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                discard_d = 1'b0;
            end
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
            addr_q    <= {ROM_ADDR_W{1'b0}};
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            addr_q    <= addr_d;
        end
    end

    assign pop_s    = op_valid && op_ready;
    assign rom_req  = (state_q == REQ);
    assign cchld    = (state_q == REQ);
    assign rom_addr = addr_q;
    // A reload during ADV means the PC is already being rewritten; advancing it would corrupt the target.
    assign pcen     = (state_q == ADV) && !flush;

    superfx_opcode_fifo #(
        .DEPTH(QDEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .flush_i     (flush),
        .push_i      (push_s),
        .push_data_i (rom_data),
        .pop_i       (pop_s),
        .valid_o     (op_valid),
        .head_o      (op_data),
        .full_o      (full_s)
    );

endmodule

// File: tb/tb_superfx_fetch_unit.sv
// Bench for superfx_fetch_unit: directed scenarios plus a randomized run checked by a scoreboard.
module tb_superfx_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic        flush;
    logic [15:0] pc;
    logic [7:0]  pbr;
    logic        pcen;
    logic        cchld;
    logic        rom_req;
    logic [23:0] rom_addr;
    logic        rom_ack;
    logic [7:0]  rom_data;
    logic        op_valid;
    logic [7:0]  op_data;
    logic        op_ready;

    superfx_fetch_unit dut (
        .clk      (clk),
        .reset    (reset),
        .go       (go),
        .flush    (flush),
        .pc       (pc),
        .pbr      (pbr),
        .pcen     (pcen),
        .cchld    (cchld),
        .rom_req  (rom_req),
        .rom_addr (rom_addr),
        .rom_ack  (rom_ack),
        .rom_data (rom_data),
        .op_valid (op_valid),
        .op_data  (op_data),
        .op_ready (op_ready)
    );

    always #5 clk = ~clk;

    int          errors = 0;
    int          checks = 0;
    logic        pcen_l = 1'b0;
    bit          mon_en = 1'b0;
    logic [7:0]  exp_q [$];
    logic [15:0] fetch_ptr;
    bit          req_active;
    bit          flushed;
    int          lat;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ROM content is a function of the byte address, so a wrong address shows up as wrong data.
    function automatic logic [7:0] rom_f(input logic [23:0] a);
        logic [7:0] t;
        t = a[7:0] + a[15:8] * 8'd7 + a[23:16] * 8'd13;
        return t ^ 8'h5A;
    endfunction

    always @(negedge clk) pcen_l <= pcen;

    // One clock; the bench's R15 advances when the DUT asked for it last cycle.
    task automatic step();
        @(posedge clk);
        #1;
        if (pcen_l) pc = pc + 16'd1;
    endtask

    task automatic do_reset();
        reset = 1'b1; go = 1'b0; flush = 1'b0; rom_ack = 1'b0; rom_data = 8'h00;
        op_ready = 1'b0; pc = 16'h0000; pbr = 8'h00;
        req_active = 1'b0; flushed = 1'b0; lat = 0;
        step(); step();
        chk("rst_rom_req", {31'd0, rom_req}, 32'd0);
        chk("rst_cchld", {31'd0, cchld}, 32'd0);
        chk("rst_pcen", {31'd0, pcen}, 32'd0);
        chk("rst_rom_addr", {8'd0, rom_addr}, 32'd0);
        chk("rst_op_valid", {31'd0, op_valid}, 32'd0);
        chk("rst_op_data", {24'd0, op_data}, 32'd0);
        reset = 1'b0;
        step();
    endtask

    task automatic wait_req(output bit got);
        got = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (rom_req) begin
                got = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic fetch_one(input logic [7:0] d);
        bit got;
        wait_req(got);
        chk("req_seen", {31'd0, got}, 32'd1);
        if (got) begin
            rom_ack = 1'b1; rom_data = d;
            step();
            rom_ack = 1'b0;
        end
    endtask

    // ROM responder for the random run; expected bytes go to the scoreboard in program order.
    task automatic rom_cycle(input bit allow_flush);
        bit f;
        rom_ack = 1'b0;
        flush   = 1'b0;
        if (rom_req && !req_active) begin
            req_active = 1'b1; flushed = 1'b0; lat = $urandom_range(0, 3);
        end
        f = allow_flush && ($urandom_range(0, 19) == 0);
        if (req_active) begin
            if (lat == 0) begin
                rom_ack  = 1'b1;
                rom_data = rom_f(rom_addr);
                if (!flushed) chk("rom_addr", {8'd0, rom_addr}, {8'd0, pbr, fetch_ptr});
                if (!flushed && !f) begin
                    exp_q.push_back(rom_f({pbr, fetch_ptr}));
                    fetch_ptr = fetch_ptr + 16'd1;
                end
                req_active = 1'b0;
            end else begin
                lat--;
            end
        end
        if (f) begin
            flush = 1'b1;
            pc    = 16'($urandom);
            if ($urandom_range(0, 3) == 0) pbr = 8'($urandom);
            fetch_ptr = pc;
            exp_q.delete();
            if (req_active) flushed = 1'b1;
        end
    endtask

    // Scoreboard monitor: every byte the decoder takes must be the next expected one.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            chk("cchld_eq_req", {31'd0, cchld}, {31'd0, rom_req});
            if (flush) chk("pcen_in_flush", {31'd0, pcen}, 32'd0);
            if (op_valid && op_ready && !flush) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_byte", {24'd0, op_data}, 32'hFFFF_FFFF);
                end else begin
                    chk("op_data", {24'd0, op_data}, {24'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit got;
        int n;

        // Basic fetch from bank 01, pc 8000.
        do_reset();
        pbr = 8'h01; pc = 16'h8000; go = 1'b1;
        wait_req(got);
        chk("a_req", {31'd0, got}, 32'd1);
        chk("a_addr", {8'd0, rom_addr}, 32'h0001_8000);
        chk("a_cchld", {31'd0, cchld}, 32'd1);
        rom_ack = 1'b1; rom_data = 8'hA5;
        step();
        rom_ack = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (pcen) n++;
            step();
        end
        chk("a_pcen_pulses", n, 32'd1);
        chk("a_valid", {31'd0, op_valid}, 32'd1);
        chk("a_data", {24'd0, op_data}, 32'h0000_00A5);

        // Full queue blocks requests until the decoder pops.
        do_reset();
        pbr = 8'h01; pc = 16'h1000; go = 1'b1;
        fetch_one(8'h11);
`ifdef SUPERFX_FETCH_PREFETCH_EN
        fetch_one(8'h22);
`endif
        n = 0;
        for (int i = 0; i < 8; i++) begin
            if (rom_req) n++;
            step();
        end
        chk("b_no_req_when_full", n, 32'd0);
        chk("b_head", {24'd0, op_data}, 32'h0000_0011);
        op_ready = 1'b1; step(); op_ready = 1'b0;
`ifdef SUPERFX_FETCH_PREFETCH_EN
        chk("b_second_valid", {31'd0, op_valid}, 32'd1);
        chk("b_second", {24'd0, op_data}, 32'h0000_0022);
        op_ready = 1'b1; step(); op_ready = 1'b0;
        chk("b_drained", {31'd0, op_valid}, 32'd0);
`else
        chk("b_empty", {31'd0, op_valid}, 32'd0);
        wait_req(got);
        chk("b_req_after_pop", {31'd0, got}, 32'd1);
        chk("b_next_addr", {8'd0, rom_addr}, 32'h0001_1001);
`endif
        go = 1'b0;

        // Flush during REQ discards the returning byte.
        do_reset();
        pbr = 8'h02; pc = 16'h2000; go = 1'b1;
        wait_req(got);
        chk("c_req", {31'd0, got}, 32'd1);
        flush = 1'b1; step(); flush = 1'b0;
        n = 0;
        rom_ack = 1'b1; rom_data = 8'h33;
        step();
        rom_ack = 1'b0; go = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (pcen) n++;
            step();
        end
        chk("c_pcen_pulses", n, 32'd0);
        chk("c_valid", {31'd0, op_valid}, 32'd0);

`ifdef SUPERFX_FETCH_PREFETCH_EN
        // Push and pop in the same cycle with one entry held.
        do_reset();
        pbr = 8'h03; pc = 16'h3000; go = 1'b1;
        fetch_one(8'h44);
        wait_req(got);
        chk("d_req", {31'd0, got}, 32'd1);
        rom_ack = 1'b1; rom_data = 8'h55; op_ready = 1'b1;
        step();
        rom_ack = 1'b0; op_ready = 1'b0; go = 1'b0;
        chk("d_valid", {31'd0, op_valid}, 32'd1);
        chk("d_data", {24'd0, op_data}, 32'h0000_0055);
        op_ready = 1'b1; step(); op_ready = 1'b0;
        chk("d_single_entry", {31'd0, op_valid}, 32'd0);
`endif

        // Reset in the middle of an access; the late ack must be ignored.
        do_reset();
        pbr = 8'h04; pc = 16'h4000; go = 1'b1;
        wait_req(got);
        chk("e_req", {31'd0, got}, 32'd1);
        reset = 1'b1;
        #1;
        chk("e_rst_req", {31'd0, rom_req}, 32'd0);
        chk("e_rst_cchld", {31'd0, cchld}, 32'd0);
        chk("e_rst_addr", {8'd0, rom_addr}, 32'd0);
        go = 1'b0;
        step();
        reset = 1'b0;
        rom_ack = 1'b1; rom_data = 8'h77;
        step();
        rom_ack = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (pcen || rom_req || op_valid) n++;
            step();
        end
        chk("e_quiet_after_ack", n, 32'd0);

        // Randomized run against the scoreboard.
        do_reset();
        pbr = 8'($urandom); pc = 16'($urandom); fetch_ptr = pc;
        exp_q.delete();
        mon_en = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step();
            go       = ($urandom_range(0, 9) != 0);
            op_ready = 1'($urandom_range(0, 1));
            rom_cycle(1'b1);
        end
        for (int i = 0; i < 40; i++) begin
            step();
            go = 1'b0; op_ready = 1'b1;
            rom_cycle(1'b0);
        end
        step();
        chk("drain_scoreboard", exp_q.size(), 32'd0);
        chk("drain_valid", {31'd0, op_valid}, 32'd0);
        chk("drain_req", {31'd0, rom_req}, 32'd0);
        mon_en = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
